// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the SN74145 scan controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, decoder enable triples {cs, n_cs_0, n_cs_1}, BCD range check.
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Decoder enable triples, ordered {cs, n_cs_0, n_cs_1}.
  localparam logic [2:0] DEC_ON  = 3'b100;
  localparam logic [2:0] DEC_OFF = 3'b011;

  // A nibble is a displayable decimal digit only in 0..9.
  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/scan_timer_v.sv
// Reloadable down-counter that times the BLANK and SHOW phases.
// Latency: done_o is high in the last cycle of a start_i-loaded interval of load_i cycles.
// Backpressure: none; free-running once loaded, parks at zero.
// Ports:
//   clk_i      clock, rising edge
//   n_rst_i    synchronous active-low reset
//   start_i    reload the counter with load_i on this edge
//   load_i     interval length in cycles (>=1)
//   cnt_nxt_o  value the counter takes on the next edge
//   done_o     current cycle is the last cycle of the interval
module scan_timer_v #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter holds load_i in the first cycle of the interval and 1 in the last.
  assign cnt_nxt_o = cnt_d;
  assign done_o    = (cnt_q == W'(1));

endmodule

// File: rtl/bcd_scan_ctrl_v.sv
// Multiplexed scan controller driving an SN74145 decoder with one-hot digit selects.
// Latency: all outputs registered; first lit cycle is 1+BLANK_CYC cycles after i_en rises.
// Backpressure: o_load_ready drops while a mid-frame load waits for the frame wrap.
// Ports:
//   i_clk, i_n_rst            clock, synchronous active-low reset
//   i_en                      1 = scanning, 0 = dark
//   i_load_valid/i_load_data  new display value (digit k at [4k+3:4k]); o_load_ready accepts
//   o_a..o_d                  BCD to decoder (a = weight 8)
//   o_cs, o_n_cs_0, o_n_cs_1  decoder enables
//   o_digit_sel, o_digit_idx  one-hot digit drive and addressed index
//   o_frame_done              pulse in the last cycle of each full scan
module bcd_scan_ctrl_v
  import bcd_scan_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                        i_clk,
  input  logic                        i_n_rst,
  input  logic                        i_en,
  input  logic                        i_load_valid,
  input  logic [4*N_DIGITS-1:0]       i_load_data,
  output logic                        o_load_ready,
  output logic                        o_a,
  output logic                        o_b,
  output logic                        o_c,
  output logic                        o_d,
  output logic                        o_cs,
  output logic                        o_n_cs_0,
  output logic                        o_n_cs_1,
  output logic [N_DIGITS-1:0]         o_digit_sel,
  output logic [$clog2(N_DIGITS)-1:0] o_digit_idx,
  output logic                        o_frame_done
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int DW   = 4 * N_DIGITS;
  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [IW-1:0]       LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic [TW-1:0]       DWELL_LD = TW'(DWELL_CYC);
  localparam logic [TW-1:0]       BLANK_LD = TW'(BLANK_CYC);
  localparam logic [N_DIGITS-1:0] SEL_ONE  = N_DIGITS'(1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] act_q, act_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          pend_q, pend_d;

  logic [2:0]          dec_q, dec_d;
  logic [3:0]          abcd_q, abcd_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic                fd_q, fd_d;
  logic                rdy_q, rdy_d;

  logic          wrap, to_idle, xfer;
  logic          t_start, t_done;
  logic [TW-1:0] t_load, t_cnt_nxt;
  logic [3:0]    digit;

  // ---------------- FSM and digit index ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    to_idle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_BLANK;
          idx_d   = '0;
        end
      end
      ST_BLANK: begin
        if (!i_en) begin
          to_idle = 1'b1;
        end else if (t_done) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!i_en) begin
          to_idle = 1'b1;
        end else if (t_done) begin
          state_d = ST_BLANK;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (to_idle) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  // Every entry into BLANK or SHOW reloads the shared timer.
  assign t_start = (state_d != state_q) && (state_d != ST_IDLE);
  assign t_load  = (state_d == ST_SHOW) ? DWELL_LD : BLANK_LD;

  scan_timer_v #(.W(TW)) u_timer (
    .clk_i     (i_clk),
    .n_rst_i   (i_n_rst),
    .start_i   (t_start),
    .load_i    (t_load),
    .cnt_nxt_o (t_cnt_nxt),
    .done_o    (t_done)
  );

  // ---------------- Load handshake ----------------
  // While scanning, new data parks in the shadow register so the active
  // register only changes at a frame boundary (or when the display goes dark).
  assign xfer = i_load_valid && rdy_q;

  always_comb begin
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    if (state_q == ST_IDLE) begin
      if (xfer) act_d = i_load_data;
    end else if (to_idle) begin
      if (xfer) begin
        act_d = i_load_data;
      end else if (pend_q) begin
        act_d = sh_q;
      end
      pend_d = 1'b0;
    end else begin
      if (wrap && pend_q) begin
        act_d  = sh_q;
        pend_d = 1'b0;
      end
      // xfer implies no load was pending, so this never clobbers the copy above.
      if (xfer) begin
        sh_d   = i_load_data;
        pend_d = 1'b1;
      end
    end
    rdy_d = !pend_d;
  end

  // ---------------- Output decode ----------------
  // Outputs are decoded from next-state values so the registered outputs
  // line up exactly with the registered state.
  assign digit = act_d[{idx_d, 2'b00} +: 4];

  always_comb begin
    dec_d  = DEC_OFF;
    abcd_d = '0;
    sel_d  = '0;
    fd_d   = 1'b0;
    case (state_d)
      ST_BLANK: abcd_d = digit;
      ST_SHOW: begin
        abcd_d = digit;
        sel_d  = SEL_ONE << idx_d;
        if (bcd_valid(digit)) dec_d = DEC_ON;
        fd_d   = (idx_d == LAST_IDX) && (t_cnt_nxt == TW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      act_q   <= '0;
      sh_q    <= '0;
      pend_q  <= 1'b0;
      dec_q   <= DEC_OFF;
      abcd_q  <= '0;
      sel_q   <= '0;
      fd_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      dec_q   <= dec_d;
      abcd_q  <= abcd_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
      rdy_q   <= rdy_d;
    end
  end

  assign {o_cs, o_n_cs_0, o_n_cs_1} = dec_q;
  assign {o_a, o_b, o_c, o_d}       = abcd_q;
  assign o_digit_sel                = sel_q;
  assign o_digit_idx                = idx_q;
  assign o_frame_done               = fd_q;
  assign o_load_ready               = rdy_q;

endmodule

// File: tb/tb_bcd_scan_ctrl_v.sv
// Bench for bcd_scan_ctrl_v with N_DIGITS=4, DWELL_CYC=4, BLANK_CYC=2 (24-cycle frame).
// Latency: outputs compared 1 ns after each rising edge against a one-deep scoreboard.
// Backpressure: load attempts while ready is low exercise the ignored-data path.
module tb_bcd_scan_ctrl_v;

  localparam int ND    = 4;
  localparam int DWC   = 4;
  localparam int BLC   = 2;
  localparam int SLOT  = DWC + BLC;
  localparam int FRAME = ND * SLOT;

  localparam logic [2:0] ON  = 3'b100;
  localparam logic [2:0] OFF = 3'b011;

  typedef struct packed {
    logic       rdy;
    logic [2:0] dec;
    logic [3:0] abcd;
    logic [3:0] sel;
    logic [1:0] idx;
    logic       fd;
  } out_t;

  typedef struct {
    int   tst;
    int   cyc;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        en = 1'b0;
  logic        lv = 1'b0;
  logic [15:0] ld = '0;

  logic       load_ready, a, b, c, d, cs, n_cs_0, n_cs_1, frame_done;
  logic [3:0] digit_sel;
  logic [1:0] digit_idx;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl[$];
  out_t sb[$];

  // Reference model: position within the frame rather than FSM + timer.
  logic        m_run  = 1'b0;
  int          m_pos  = 0;
  logic [15:0] m_act  = '0;
  logic [15:0] m_sh   = '0;
  logic        m_pend = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_ctrl_v #(.N_DIGITS(ND), .DWELL_CYC(DWC), .BLANK_CYC(BLC)) dut (
    .i_clk        (clk),
    .i_n_rst      (n_rst),
    .i_en         (en),
    .i_load_valid (lv),
    .i_load_data  (ld),
    .o_load_ready (load_ready),
    .o_a          (a),
    .o_b          (b),
    .o_c          (c),
    .o_d          (d),
    .o_cs         (cs),
    .o_n_cs_0     (n_cs_0),
    .o_n_cs_1     (n_cs_1),
    .o_digit_sel  (digit_sel),
    .o_digit_idx  (digit_idx),
    .o_frame_done (frame_done)
  );

  function automatic vec_t v(input int tst, input int cyc, input logic rdy, input logic [2:0] dec,
                             input logic [3:0] abcd, input logic [3:0] sel, input logic [1:0] idx,
                             input logic fd);
    vec_t r;
    r.tst = tst;
    r.cyc = cyc;
    r.exp = '{rdy: rdy, dec: dec, abcd: abcd, sel: sel, idx: idx, fd: fd};
    return r;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o = '{rdy: load_ready, dec: {cs, n_cs_0, n_cs_1}, abcd: {a, b, c, d},
          sel: digit_sel, idx: digit_idx, fd: frame_done};
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b dec=%b abcd=%b sel=%b idx=%0d fd=%b, expected rdy=%b dec=%b abcd=%b sel=%b idx=%0d fd=%b",
               name, act.rdy, act.dec, act.abcd, act.sel, act.idx, act.fd,
               exp.rdy, exp.dec, exp.abcd, exp.sel, exp.idx, exp.fd);
    end
  endtask

  task automatic model_step(input logic rst, input logic e, input logic l, input logic [15:0] dat);
    logic x;
    x = l && !m_pend;
    if (!rst) begin
      m_run = 1'b0; m_pos = 0; m_act = '0; m_sh = '0; m_pend = 1'b0;
    end else if (!m_run) begin
      if (x) m_act = dat;
      if (e) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (!e) begin
      m_run = 1'b0;
      m_pos = 0;
      if (x) m_act = dat;
      else if (m_pend) m_act = m_sh;
      m_pend = 1'b0;
    end else begin
      if (m_pos == FRAME - 1) begin
        m_pos = 0;
        if (m_pend) begin
          m_act  = m_sh;
          m_pend = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (x) begin
        m_sh   = dat;
        m_pend = 1'b1;
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    int   slot;
    logic [3:0] dg;
    o = '{rdy: !m_pend, dec: OFF, abcd: 4'h0, sel: 4'h0, idx: 2'd0, fd: 1'b0};
    if (m_run) begin
      slot   = m_pos / SLOT;
      dg     = 4'(m_act >> (4 * slot));
      o.idx  = 2'(slot);
      o.abcd = dg;
      if ((m_pos % SLOT) >= BLC) begin
        o.sel = 4'(1 << slot);
        o.dec = (dg <= 4'd9) ? ON : OFF;
      end
      o.fd = (m_pos == FRAME - 1);
    end
    return o;
  endfunction

  // One clock: drive inputs, queue the model's prediction, compare after the edge.
  task automatic cycle(input logic rst, input logic e, input logic l, input logic [15:0] dat);
    n_rst = rst;
    en    = e;
    lv    = l;
    ld    = dat;
    model_step(rst, e, l, dat);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    check("scoreboard", dut_out(), sb.pop_front());
  endtask

  // Enabled run: observed cycle k is the cycle after the k-th edge with i_en=1.
  task automatic run(input int tst, input int ncyc, input int drop_c, input int load_c,
                     input logic [15:0] load_v, input int rst_c);
    for (int k = 0; k < ncyc; k++) begin
      logic        l;
      logic [15:0] dat;
      l   = (load_c >= 0) && ((k == load_c) || (k == load_c + 4));
      dat = (k == load_c) ? load_v : (l ? 16'h9999 : 16'($urandom));
      cycle(k != rst_c, k != drop_c, l, dat);
      foreach (tbl[i]) begin
        if (tbl[i].tst == tst && tbl[i].cyc == k + 1) begin
          check($sformatf("t%0d_cyc%0d", tst, k + 1), dut_out(), tbl[i].exp);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    out_t rst_exp;
    rst_exp = '{rdy: 1'b1, dec: OFF, abcd: 4'h0, sel: 4'h0, idx: 2'd0, fd: 1'b0};

    // 0x1234 then 0x5678 loaded mid-frame at cycle 10
    tbl.push_back(v(2,  1, 1, OFF, 4'h4, 4'b0000, 0, 0));
    tbl.push_back(v(2,  3, 1, ON,  4'h4, 4'b0001, 0, 0));
    tbl.push_back(v(2,  6, 1, ON,  4'h4, 4'b0001, 0, 0));
    tbl.push_back(v(2,  7, 1, OFF, 4'h3, 4'b0000, 1, 0));
    tbl.push_back(v(2,  9, 1, ON,  4'h3, 4'b0010, 1, 0));
    tbl.push_back(v(2, 11, 0, ON,  4'h3, 4'b0010, 1, 0));
    tbl.push_back(v(2, 15, 0, ON,  4'h2, 4'b0100, 2, 0));
    tbl.push_back(v(2, 21, 0, ON,  4'h1, 4'b1000, 3, 0));
    tbl.push_back(v(2, 24, 0, ON,  4'h1, 4'b1000, 3, 1));
    tbl.push_back(v(2, 25, 1, OFF, 4'h8, 4'b0000, 0, 0));
    tbl.push_back(v(2, 27, 1, ON,  4'h8, 4'b0001, 0, 0));
    tbl.push_back(v(2, 33, 1, ON,  4'h7, 4'b0010, 1, 0));
    tbl.push_back(v(2, 39, 1, ON,  4'h6, 4'b0100, 2, 0));
    tbl.push_back(v(2, 45, 1, ON,  4'h5, 4'b1000, 3, 0));
    tbl.push_back(v(2, 48, 1, ON,  4'h5, 4'b1000, 3, 1));
    // 0x1A34: slot 2 holds a non-decimal nibble
    tbl.push_back(v(4,  3, 1, ON,  4'h4, 4'b0001, 0, 0));
    tbl.push_back(v(4,  9, 1, ON,  4'h3, 4'b0010, 1, 0));
    tbl.push_back(v(4, 13, 1, OFF, 4'hA, 4'b0000, 2, 0));
    tbl.push_back(v(4, 15, 1, OFF, 4'hA, 4'b0100, 2, 0));
    tbl.push_back(v(4, 18, 1, OFF, 4'hA, 4'b0100, 2, 0));
    tbl.push_back(v(4, 21, 1, ON,  4'h1, 4'b1000, 3, 0));
    tbl.push_back(v(4, 24, 1, ON,  4'h1, 4'b1000, 3, 1));
    // i_en dropped in SHOW of idx2, re-enabled one cycle later
    tbl.push_back(v(5, 16, 1, OFF, 4'hA, 4'b0100, 2, 0));
    tbl.push_back(v(5, 17, 1, OFF, 4'h0, 4'b0000, 0, 0));
    tbl.push_back(v(5, 18, 1, OFF, 4'h4, 4'b0000, 0, 0));
    tbl.push_back(v(5, 19, 1, OFF, 4'h4, 4'b0000, 0, 0));
    tbl.push_back(v(5, 20, 1, ON,  4'h4, 4'b0001, 0, 0));
    // load pending at cycle 5, reset at cycle 10
    tbl.push_back(v(6,  5, 1, ON,  4'h4, 4'b0001, 0, 0));
    tbl.push_back(v(6,  6, 0, ON,  4'h4, 4'b0001, 0, 0));
    tbl.push_back(v(6, 11, 1, OFF, 4'h0, 4'b0000, 0, 0));
    tbl.push_back(v(6, 12, 1, OFF, 4'h0, 4'b0000, 0, 0));
    tbl.push_back(v(6, 14, 1, ON,  4'h0, 4'b0001, 0, 0));

    // Reset held for three cycles
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 16'(k));
    check("reset", dut_out(), rst_exp);

    // IDLE load goes straight to the active register
    cycle(1'b1, 1'b0, 1'b1, 16'h1234);
    check("idle_load", dut_out(), rst_exp);

    run(2, 50, -1, 10, 16'h5678, -1);

    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b1, 16'h1A34);
    run(4, 26, -1, -1, 16'h0, -1);

    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    run(5, 22, 16, -1, 16'h0, -1);

    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    run(6, 16, -1, 5, 16'h4321, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
